// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: emits a one-cycle tick every div_active
// clocks and a 50%-duty div_clk that toggles on each tick.
module clk_div_prog #(
    parameter int unsigned CNT_WIDTH   = 17,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync,
    input  logic [CNT_WIDTH-1:0] div_val,
    input  logic                 div_load,
    output logic                 tick,
    output logic                 div_clk,
    output logic                 div_pend,
    output logic [CNT_WIDTH-1:0] div_active
);

    localparam logic [CNT_WIDTH-1:0] DEF_DIV = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] active_q, active_d;
    logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
    logic                 tick_q, tick_d;
    logic                 div_clk_q, div_clk_d;
    logic                 pend_q, pend_d;

    logic [CNT_WIDTH-1:0] div_sane;
    logic                 wrap;

    assign div_sane = (div_val == '0) ? ONE : div_val;
    assign wrap     = (count_q == active_q - ONE);

    always_comb begin
        count_d   = count_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        tick_d    = 1'b0;
        div_clk_d = div_clk_q;
        pend_d    = pend_q;

        if (sync) begin
            count_d   = '0;
            div_clk_d = 1'b0;
            pend_d    = 1'b0;
            if (div_load) begin
                active_d = div_sane;
            end else if (pend_q) begin
                active_d = shadow_q;
            end
        end else if (en) begin
            if (wrap) begin
                // A new divisor only takes over at a period boundary.
                count_d   = '0;
                tick_d    = 1'b1;
                div_clk_d = ~div_clk_q;
                pend_d    = 1'b0;
                if (div_load) begin
                    active_d = div_sane;
                end else if (pend_q) begin
                    active_d = shadow_q;
                end
            end else begin
                count_d = count_q + ONE;
                if (div_load) begin
                    shadow_d = div_sane;
                    pend_d   = 1'b1;
                end
            end
        end else if (div_load) begin
            active_d = div_sane;
            count_d  = '0;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            active_q  <= DEF_DIV;
            shadow_q  <= DEF_DIV;
            tick_q    <= 1'b0;
            div_clk_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            tick_q    <= tick_d;
            div_clk_q <= div_clk_d;
            pend_q    <= pend_d;
        end
    end

    assign tick       = tick_q;
    assign div_clk    = div_clk_q;
    assign div_pend   = pend_q;
    assign div_active = active_q;

endmodule
